// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle RV32I controller and its shared-memory datapath.
// The illegal_o flag exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
    parameter int unsigned ALUC_W = 4
);
    logic [6:0]        Op;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              Zero;
    logic              mem_ready;
    logic              PCWrite;
    logic              AdrSrc;
    logic              MemWrite;
    logic              IRWrite;
    logic [1:0]        ResultSrc;
    logic [1:0]        ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [1:0]        ImmSrc;
    logic              RegWrite;
    logic [ALUC_W-1:0] ALUControl;
    logic [3:0]        state_o;
`ifdef ILLEGAL_TRAP_EN
    logic              illegal_o;

    modport slave (
        input  Op, funct3, funct7, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, state_o, illegal_o
    );

    modport master (
        output Op, funct3, funct7, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, state_o, illegal_o
    );
`else
    modport slave (
        input  Op, funct3, funct7, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, state_o
    );

    modport master (
        output Op, funct3, funct7, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, state_o
    );
`endif
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with a memory ready handshake.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP and raise sticky illegal_o.
module multicycle_control_unit #(
    parameter int unsigned ALUC_W = 4,
    parameter bit          MEM_HS = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    multicycle_control_unit_if.slave bus
);

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd8;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP = 4'd11
`endif
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic       reg_write;
    } moore_t;

    localparam moore_t MOORE_FETCH = '{
        adr_src: 1'b0, mem_write: 1'b0, result_src: 2'b10, alu_src_a: 2'b00,
        alu_src_b: 2'b10, imm_src: 2'b00, reg_write: 1'b0
    };

    state_t                r_state;
    state_t                w_next;
    moore_t                r_moore;
    moore_t                w_moore;
    logic                  w_ready;
    logic                  w_pc_write;
    logic                  w_ir_write;
    logic [ALU_OP_W-1:0]   w_alu_op;
`ifdef ILLEGAL_TRAP_EN
    logic                  r_illegal;
`endif

    function automatic logic [ALU_OP_W-1:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                                       input logic is_r);
        logic [ALU_OP_W-1:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_ADD;
            3'b100: op = ALU_XOR;
            3'b101: op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign w_ready = bus.mem_ready | !MEM_HS;

    // Next-state sequencing
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXER;
                    OP_ITYPE:          w_next = S_EXEI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:           w_next = S_TRAP;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: w_next = (bus.Op == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
            S_EXER:   w_next = S_ALUWB;
            S_EXEI:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JAL:    w_next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   w_next = S_TRAP;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore outputs of the state being entered, so they leave the flops with the state
    always_comb begin
        w_moore = '0;
        case (w_next)
            S_FETCH:  w_moore = MOORE_FETCH;
            S_DECODE: begin
                w_moore.alu_src_a = 2'b01;
                w_moore.alu_src_b = 2'b01;
                w_moore.imm_src   = 2'b10;
            end
            S_MEMADR: begin
                w_moore.alu_src_a = 2'b10;
                w_moore.alu_src_b = 2'b01;
                w_moore.imm_src   = (bus.Op == OP_STORE) ? 2'b01 : 2'b00;
            end
            S_MEMRD:  w_moore.adr_src = 1'b1;
            S_MEMWB: begin
                w_moore.result_src = 2'b01;
                w_moore.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_moore.adr_src   = 1'b1;
                w_moore.mem_write = 1'b1;
            end
            S_EXER:   w_moore.alu_src_a = 2'b10;
            S_EXEI: begin
                w_moore.alu_src_a = 2'b10;
                w_moore.alu_src_b = 2'b01;
            end
            S_ALUWB:  w_moore.reg_write = 1'b1;
            S_BRANCH: w_moore.alu_src_a = 2'b10;
            S_JAL: begin
                w_moore.alu_src_a = 2'b01;
                w_moore.alu_src_b = 2'b10;
            end
            default:  w_moore = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_moore   <= MOORE_FETCH;
`ifdef ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_moore <= w_moore;
`ifdef ILLEGAL_TRAP_EN
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
`endif
        end
    end

    // Input-dependent outputs: fetch handshake, branch decision, ALU op decode
    always_comb begin
        w_pc_write = 1'b0;
        w_ir_write = 1'b0;
        w_alu_op   = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_pc_write = w_ready;
                w_ir_write = w_ready;
            end
            S_EXER:   w_alu_op = alu_decode(bus.funct3, bus.funct7[5], 1'b1);
            S_EXEI:   w_alu_op = alu_decode(bus.funct3, bus.funct7[5], 1'b0);
            S_BRANCH: begin
                w_alu_op = ALU_SUB;
                case (bus.funct3)
                    3'b000:  w_pc_write = bus.Zero;
                    3'b001:  w_pc_write = !bus.Zero;
                    default: w_pc_write = 1'b0;
                endcase
            end
            S_JAL:    w_pc_write = 1'b1;
            default: begin
                w_pc_write = 1'b0;
                w_ir_write = 1'b0;
            end
        endcase
    end

    assign bus.PCWrite    = w_pc_write;
    assign bus.IRWrite    = w_ir_write;
    assign bus.ALUControl = ALUC_W'(w_alu_op);
    assign bus.AdrSrc     = r_moore.adr_src;
    assign bus.MemWrite   = r_moore.mem_write;
    assign bus.ResultSrc  = r_moore.result_src;
    assign bus.ALUSrcA    = r_moore.alu_src_a;
    assign bus.ALUSrcB    = r_moore.alu_src_b;
    assign bus.ImmSrc     = r_moore.imm_src;
    assign bus.RegWrite   = r_moore.reg_write;
    assign bus.state_o    = r_state;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_o  = r_illegal;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed cases then random instruction stream,
// each cycle compared against an instruction-level trace model (state path plus per-state outputs).
module tb_multicycle_control_unit;

    localparam int unsigned ALUC_W = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
    localparam int EXER = 6, EXEI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, TRAP = 11;

    typedef int int_q_t[$];
    typedef struct {
        int st;
        bit rdy;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    multicycle_control_unit_if #(.ALUC_W(ALUC_W)) u_if ();

    multicycle_control_unit #(
        .ALUC_W(ALUC_W),
        .MEM_HS(1'b1)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int alu_ref(input bit is_r, input logic [2:0] f3, input logic [6:0] f7);
        logic [6:0] f;
        f = f7;
        case (f3)
            3'd0:    return (is_r && f[5]) ? 1 : 0;
            3'd1:    return 6;
            3'd2:    return 5;
            3'd3:    return 0;
            3'd4:    return 4;
            3'd5:    return f[5] ? 8 : 7;
            3'd6:    return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_R || op == OP_I ||
               op == OP_BR || op == OP_JAL;
    endfunction

    // Instruction-level state trace with zero wait states
    function automatic int_q_t path_for(input logic [6:0] op);
        int_q_t p;
        p = '{FETCH, DECODE};
        if (op == OP_LOAD)       p = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
        else if (op == OP_STORE) p = '{FETCH, DECODE, MEMADR, MEMWR};
        else if (op == OP_R)     p = '{FETCH, DECODE, EXER, ALUWB};
        else if (op == OP_I)     p = '{FETCH, DECODE, EXEI, ALUWB};
        else if (op == OP_BR)    p = '{FETCH, DECODE, BRANCH};
        else if (op == OP_JAL)   p = '{FETCH, DECODE, JAL, ALUWB};
        return p;
    endfunction

    // Drive mem_ready, check state and every output the current state defines, then advance a cycle
    task automatic check_step(input int st, input bit rdy);
        logic e_pcw, e_irw, e_mw, e_rw;
        u_if.mem_ready = rdy;
        #1;
        e_pcw = 1'b0;
        e_irw = 1'b0;
        e_mw  = 1'b0;
        e_rw  = 1'b0;
        chk($sformatf("state(exp %0d)", st), 32'(u_if.state_o), 32'(st));
        case (st)
            FETCH: begin
                e_pcw = rdy;
                e_irw = rdy;
                chk("fetch.AdrSrc", 32'(u_if.AdrSrc), 0);
                chk("fetch.ALUSrcA", 32'(u_if.ALUSrcA), 0);
                chk("fetch.ALUSrcB", 32'(u_if.ALUSrcB), 2);
                chk("fetch.ResultSrc", 32'(u_if.ResultSrc), 2);
                chk("fetch.ALUControl", 32'(u_if.ALUControl), 0);
            end
            DECODE: begin
                chk("decode.ALUSrcA", 32'(u_if.ALUSrcA), 1);
                chk("decode.ALUSrcB", 32'(u_if.ALUSrcB), 1);
                chk("decode.ImmSrc", 32'(u_if.ImmSrc), 2);
                chk("decode.ALUControl", 32'(u_if.ALUControl), 0);
            end
            MEMADR: begin
                chk("memadr.ALUSrcA", 32'(u_if.ALUSrcA), 2);
                chk("memadr.ALUSrcB", 32'(u_if.ALUSrcB), 1);
                chk("memadr.ALUControl", 32'(u_if.ALUControl), 0);
                chk("memadr.ImmSrc", 32'(u_if.ImmSrc), (u_if.Op == OP_STORE) ? 1 : 0);
            end
            MEMRD: chk("memrd.AdrSrc", 32'(u_if.AdrSrc), 1);
            MEMWB: begin
                e_rw = 1'b1;
                chk("memwb.ResultSrc", 32'(u_if.ResultSrc), 1);
            end
            MEMWR: begin
                e_mw = 1'b1;
                chk("memwr.AdrSrc", 32'(u_if.AdrSrc), 1);
            end
            EXER, EXEI: begin
                chk("exe.ALUSrcA", 32'(u_if.ALUSrcA), 2);
                chk("exe.ALUSrcB", 32'(u_if.ALUSrcB), (st == EXER) ? 0 : 1);
                chk("exe.ALUControl", 32'(u_if.ALUControl),
                    32'(alu_ref(st == EXER, u_if.funct3, u_if.funct7)));
            end
            ALUWB: begin
                e_rw = 1'b1;
                chk("aluwb.ResultSrc", 32'(u_if.ResultSrc), 0);
            end
            BRANCH: begin
                e_pcw = (u_if.funct3 == 3'd0) ? u_if.Zero :
                        (u_if.funct3 == 3'd1) ? !u_if.Zero : 1'b0;
                chk("branch.ALUSrcA", 32'(u_if.ALUSrcA), 2);
                chk("branch.ALUSrcB", 32'(u_if.ALUSrcB), 0);
                chk("branch.ALUControl", 32'(u_if.ALUControl), 1);
                chk("branch.ResultSrc", 32'(u_if.ResultSrc), 0);
            end
            JAL: begin
                e_pcw = 1'b1;
                chk("jal.ALUSrcA", 32'(u_if.ALUSrcA), 1);
                chk("jal.ALUSrcB", 32'(u_if.ALUSrcB), 2);
                chk("jal.ALUControl", 32'(u_if.ALUControl), 0);
                chk("jal.ResultSrc", 32'(u_if.ResultSrc), 0);
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                chk("trap.illegal_o", 32'(u_if.illegal_o), 1);
`endif
            end
        endcase
        chk($sformatf("s%0d.PCWrite", st), 32'(u_if.PCWrite), 32'(e_pcw));
        chk($sformatf("s%0d.IRWrite", st), 32'(u_if.IRWrite), 32'(e_irw));
        chk($sformatf("s%0d.MemWrite", st), 32'(u_if.MemWrite), 32'(e_mw));
        chk($sformatf("s%0d.RegWrite", st), 32'(u_if.RegWrite), 32'(e_rw));
        @(posedge clk);
        #1;
    endtask

    // Expand the trace with wait states on FETCH and the memory access states, then check it
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input bit z, input int wf, input int wm);
        int_q_t path;
        step_t  steps[$];
        u_if.Op     = op;
        u_if.funct3 = f3;
        u_if.funct7 = f7;
        u_if.Zero   = z;
        path = path_for(op);
        foreach (path[i]) begin
            int w;
            w = (path[i] == FETCH) ? wf : (path[i] == MEMRD || path[i] == MEMWR) ? wm : -1;
            if (w < 0) begin
                steps.push_back('{st: path[i], rdy: 1'($urandom_range(0, 1))});
            end else begin
                for (int k = 0; k < w; k++) steps.push_back('{st: path[i], rdy: 1'b0});
                steps.push_back('{st: path[i], rdy: 1'b1});
            end
        end
        foreach (steps[i]) check_step(steps[i].st, steps[i].rdy);
    endtask

    initial begin
        u_if.Op        = 7'd0;
        u_if.funct3    = 3'd0;
        u_if.funct7    = 7'd0;
        u_if.Zero      = 1'b0;
        u_if.mem_ready = 1'b0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef ILLEGAL_TRAP_EN
        chk("reset.illegal_o", 32'(u_if.illegal_o), 0);
`endif
        check_step(FETCH, 1'b0);
        rst = 1'b1;

        // R-type SUB, no wait states
        run_instr(OP_R, 3'b000, 7'b0100000, 1'b0, 0, 0);
        // Load with three wait cycles in MEMRD, and a fetch stall
        run_instr(OP_LOAD, 3'b010, 7'd0, 1'b0, 2, 3);
        // Branch outcomes
        run_instr(OP_BR, 3'b000, 7'd0, 1'b1, 0, 0);
        run_instr(OP_BR, 3'b001, 7'd0, 1'b1, 0, 0);
        run_instr(OP_BR, 3'b001, 7'd0, 1'b0, 0, 0);
        run_instr(OP_BR, 3'b100, 7'd0, 1'b1, 0, 0);
        // Store, then a store aborted by reset while held in MEMWR
        run_instr(OP_STORE, 3'b010, 7'd0, 1'b0, 0, 2);
        u_if.Op = OP_STORE;
        check_step(FETCH, 1'b1);
        check_step(DECODE, 1'b1);
        check_step(MEMADR, 1'b1);
        u_if.mem_ready = 1'b0;
        #1;
        chk("abort.state_before", 32'(u_if.state_o), MEMWR);
        chk("abort.MemWrite_before", 32'(u_if.MemWrite), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_step(FETCH, 1'b0);
        rst = 1'b1;
        // I-type shifts and no-SUB add
        run_instr(OP_I, 3'b101, 7'b0100000, 1'b0, 0, 0);
        run_instr(OP_I, 3'b000, 7'b0100000, 1'b0, 0, 0);
        run_instr(OP_JAL, 3'b000, 7'd0, 1'b0, 1, 0);

        // Unknown opcode
`ifdef ILLEGAL_TRAP_EN
        u_if.Op = OP_BAD;
        check_step(FETCH, 1'b1);
        check_step(DECODE, 1'b1);
        for (int k = 0; k < 4; k++) begin
            u_if.Zero = 1'($urandom_range(0, 1));
            check_step(TRAP, 1'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("trap.illegal_cleared", 32'(u_if.illegal_o), 0);
        check_step(FETCH, 1'b0);
        rst = 1'b1;
`else
        run_instr(OP_BAD, 3'b000, 7'd0, 1'b0, 0, 0);
`endif

        // Random instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 6))
                0:       op = OP_LOAD;
                1:       op = OP_STORE;
                2:       op = OP_R;
                3:       op = OP_I;
                4:       op = OP_BR;
                5:       op = OP_JAL;
                default: begin
                    op = 7'($urandom);
`ifdef ILLEGAL_TRAP_EN
                    if (!is_legal(op)) op = OP_R;
`else
                    if (is_legal(op)) op = OP_BAD;
`endif
                end
            endcase
            run_instr(op, 3'($urandom), 7'($urandom), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
